// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle for fifo_sync_param.
// The master side is the producer/consumer; the slave side is the FIFO itself.
interface fifo_sync_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             fifo_empty;
    logic             fifo_full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    fifo_count;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, push, pop,
        input  data_out, fifo_empty, fifo_full, almost_empty, almost_full,
               fifo_count, overflow, underflow
    );

    modport slave (
        input  data_in, push, pop,
        output data_out, fifo_empty, fifo_full, almost_empty, almost_full,
               fifo_count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// overflow/underflow pulses and selectable registered or fall-through read.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic               clk,
    input  logic               reset,
    fifo_sync_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    write_ptr;
    logic [AW-1:0]    read_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             fifo_empty;
    logic             fifo_full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;
    logic             push_acc;
    logic             pop_acc;

    // Acceptance looks only at the registered flags, so a full FIFO rejects
    // a push even when a pop frees a slot in the same cycle.
    always_comb begin
        push_acc = bus.push && !fifo_full;
        pop_acc  = bus.pop && !fifo_empty;
    end

    always_comb begin
        count_next = count;
        case ({push_acc, pop_acc})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            write_ptr    <= '0;
            read_ptr     <= '0;
            count        <= '0;
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_acc) write_ptr <= write_ptr + AW'(1);
            if (pop_acc)  read_ptr  <= read_ptr + AW'(1);
            count        <= count_next;
            fifo_empty   <= (count_next == '0);
            fifo_full    <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
            overflow     <= bus.push && fifo_full;
            underflow    <= bus.pop && fifo_empty;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (reset && push_acc) mem[write_ptr] <= bus.data_in;
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (!reset)       rd_q <= '0;
                else if (pop_acc) rd_q <= mem[read_ptr];
            end
            assign bus.data_out = rd_q;
        end else begin : g_fwft_read
            assign bus.data_out = fifo_empty ? '0 : mem[read_ptr];
        end
    endgenerate

    assign bus.fifo_empty   = fifo_empty;
    assign bus.fifo_full    = fifo_full;
    assign bus.almost_empty = almost_empty;
    assign bus.almost_full  = almost_full;
    assign bus.fifo_count   = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock synchronous FIFO: the next generation of the team's 4x4 FIFO.
- Generalised data width and depth; the full DEPTH is usable.
- Adds true simultaneous push/pop, occupancy count, programmable almost-full/almost-empty flags, sticky-free overflow/underflow error pulses, and a selectable first-word-fall-through read mode.
- Used as the standard buffering element between producer/consumer blocks in the same clock domain.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 8: number of storage entries; power of two, >=2.
- AF_LEVEL, 6: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0: read mode. 0 = registered read, 1 = first-word fall-through.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- data_in  input  WIDTH  write data
- push  input  1  write request
- pop  input  1  read request
- data_out  output  WIDTH  read data
- fifo_empty  output  1  count == 0
- fifo_full  output  1  count == DEPTH
- almost_empty  output  1  count <= AE_LEVEL
- almost_full  output  1  count >= AF_LEVEL
- fifo_count  output  clog2(DEPTH)+1  current occupancy
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected

Behaviour:
- Reset: sampled only at rising clk with reset==0.
  - Clears pointers and count.
  - data_out=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, fifo_count=0, overflow=0, underflow=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all contents; any push/pop in the reset cycle is ignored.
- Pointers: write_ptr and read_ptr are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count: clog2(DEPTH)+1 bits, registered, so count==DEPTH is representable.
- Status flags are registered and reflect count after each edge, so they are valid in the same cycle as fifo_count.
- Push accept: push && !fifo_full, evaluated on the current registered flags. Effect: mem[write_ptr] <= data_in, write_ptr++.
- Pop accept: pop && !fifo_empty. Effect: read_ptr++.
- Count update:
  - +1 on push-only accept.
  - -1 on pop-only accept.
  - Unchanged when both are accepted in the same cycle; this is legal whenever 0 < count < DEPTH.
- When full, push is rejected even if pop is accepted that cycle; count becomes DEPTH-1.
- When empty, pop is rejected even if push is accepted; count becomes 1.
- Rejected push: memory and pointers are unchanged; overflow=1 for exactly the next cycle.
- Rejected pop: data_out and pointers are unchanged; underflow=1 for exactly the next cycle.
- Error pulses: both are 0 in any cycle without a new rejection.
- FWFT=0 read path:
  - On an accepted pop, data_out <= mem[read_ptr] at the same edge, so the word is visible 1 cycle after pop is sampled.
  - data_out holds its last value otherwise, including when empty.
- FWFT=1 read path:
  - data_out presents the head word mem[read_ptr] whenever fifo_empty==0.
  - pop consumes the head, and the next word appears after the edge.
  - data_out=0 while fifo_empty==1.
  - First-write latency: a word pushed into an empty FIFO appears on data_out the cycle after the push edge, together with fifo_empty falling.
- Simultaneous push/pop with count==1 in FWFT: the head is consumed and the new word becomes head after the edge.
- Read-during-write to the same address cannot occur, because push into a full FIFO is rejected.

Test Plan:
- Reset/idle (DEPTH=8, WIDTH=8): hold reset=0 for 2 cycles, then release -> fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, fifo_count=0, data_out=0, overflow=0, underflow=0.
- Fill then drain (FWFT=0):
  - Push 0x10..0x17 on 8 consecutive cycles -> fifo_count 1..8; almost_empty deasserts at count 3; almost_full asserts at count 6; fifo_full=1 at count 8.
  - Then pop 8 cycles -> data_out 0x10..0x17, each one cycle after its pop; fifo_empty=1 at the end.
- Overflow/underflow:
  - With the FIFO full, push 0xAA -> overflow high for one cycle; count stays 8; later drain shows no 0xAA.
  - With the FIFO empty, pop -> underflow high for one cycle; data_out unchanged.
- Simultaneous push/pop and wrap: preload 4 words, then push+pop together for 20 cycles -> fifo_count stays 4; data_out sequence matches input order across multiple pointer wraps.
- Full and empty boundaries with push+pop:
  - At count=8, push+pop -> pop accepted, push rejected, overflow pulses, count=7.
  - At count=0, push+pop -> push accepted, underflow pulses, count=1.
- FWFT=1 and reset:
  - Push 0x5A into an empty FIFO -> data_out=0x5A and fifo_empty=0 on the next cycle, with no pop required.
  - Pop -> data_out=0, fifo_empty=1.
  - Reset asserted with 3 words stored -> after the edge, count=0, fifo_empty=1, data_out=0.
